// File: rtl/uni_arb_pkg.sv
// uni_arb_pkg: shared types for the IFU/LSU uni-bridge arbiter.
// Optional round-robin pick is enabled with UNI_ARB_RR_EN.
package uni_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IF,
    ARB_LS
  } arb_state_e;

  typedef enum logic {
    GNT_IF,
    GNT_LS
  } arb_gnt_e;

  localparam int WAIT_CNT_MAX = 15;

endpackage

// File: rtl/uni_if.sv
// uni_if: simple valid/ready request bus between core units and the bridge.
// Master drives the request fields; Slave returns ready, rdata and resp.
interface uni_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic              reqtyp;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        resp;

  modport Master (
    output valid, reqtyp, addr, size, wdata,
    input  ready, rdata, resp
  );

  modport Slave (
    input  valid, reqtyp, addr, size, wdata,
    output ready, rdata, resp
  );
endinterface

// File: rtl/uni_arb_pick.sv
// uni_arb_pick: winner selection between IFU and LSU requests.
// UNI_ARB_RR_EN selects round-robin; otherwise LSU has fixed priority.
module uni_arb_pick
  import uni_arb_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     if_valid,
  input  logic     ls_valid,
  input  logic     gnt_en,
  output logic     pick_valid,
  output arb_gnt_e pick
);

  assign pick_valid = if_valid | ls_valid;

`ifdef UNI_ARB_RR_EN
  arb_gnt_e last_grant;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last_grant <= GNT_IF;
    end else if (gnt_en) begin
      last_grant <= pick;
    end
  end

  // On a tie the side that did not win last time goes next.
  always_comb begin
    pick = GNT_IF;
    if (if_valid && ls_valid) begin
      pick = (last_grant == GNT_IF) ? GNT_LS : GNT_IF;
    end else if (ls_valid) begin
      pick = GNT_LS;
    end
  end
`else
  logic unused_pick;
  assign unused_pick = &{1'b0, i_clk, i_rst_n, gnt_en};

  always_comb begin
    pick = GNT_IF;
    if (ls_valid) begin
      pick = GNT_LS;
    end
  end
`endif

endmodule

// File: rtl/uni_arbiter.sv
// uni_arbiter: shares the uni-to-AXI bridge between IFU and LSU.
// Build option UNI_ARB_RR_EN enables round-robin arbitration.
module uni_arbiter
  import uni_arb_pkg::*;
#(
  parameter int UNI_ADDR_WIDTH = 32,
  parameter int UNI_DATA_WIDTH = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  uni_if.Slave       UniIf_IF,
  uni_if.Slave       UniIf_LS,
  uni_if.Master      UniIf_M,
  output logic [3:0] wait_cnt
);

  localparam logic [3:0] CNT_MAX = 4'(WAIT_CNT_MAX);

  arb_state_e state;
  arb_gnt_e   wait_who;
  arb_gnt_e   pick;
  logic       pick_valid;
  logic       gnt_en;
  logic       gnt_if;
  logic       gnt_ls;

  logic                      m_valid;
  logic                      m_reqtyp;
  logic [UNI_ADDR_WIDTH-1:0] m_addr;
  logic [1:0]                m_size;
  logic [UNI_DATA_WIDTH-1:0] m_wdata;
  logic                      if_rdy;
  logic                      ls_rdy;

  assign gnt_if = (state == ARB_IF);
  assign gnt_ls = (state == ARB_LS);
  assign gnt_en = (state == ARB_IDLE) & pick_valid;

  uni_arb_pick u_pick (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .if_valid   (UniIf_IF.valid),
    .ls_valid   (UniIf_LS.valid),
    .gnt_en     (gnt_en),
    .pick_valid (pick_valid),
    .pick       (pick)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= ARB_IDLE;
      wait_who <= GNT_IF;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state <= (pick == GNT_LS) ? ARB_LS : ARB_IF;
            if (pick == wait_who) begin
              wait_cnt <= '0;
            end
          end
        end
        ARB_IF: begin
          wait_who <= GNT_LS;
          if (UniIf_LS.valid && wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
          if (UniIf_M.ready) begin
            state <= ARB_IDLE;
          end
        end
        ARB_LS: begin
          wait_who <= GNT_IF;
          if (UniIf_IF.valid && wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
          if (UniIf_M.ready) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Valid is masked in the ready cycle so the bridge never sees a stale request.
  always_comb begin
    m_valid  = 1'b0;
    m_reqtyp = 1'b0;
    m_addr   = '0;
    m_size   = '0;
    m_wdata  = '0;
    if_rdy   = 1'b0;
    ls_rdy   = 1'b0;
    unique case (1'b1)
      gnt_if: begin
        m_valid  = UniIf_IF.valid & ~UniIf_M.ready;
        m_reqtyp = UniIf_IF.reqtyp;
        m_addr   = UniIf_IF.addr;
        m_size   = UniIf_IF.size;
        m_wdata  = UniIf_IF.wdata;
        if_rdy   = UniIf_M.ready;
      end
      gnt_ls: begin
        m_valid  = UniIf_LS.valid & ~UniIf_M.ready;
        m_reqtyp = UniIf_LS.reqtyp;
        m_addr   = UniIf_LS.addr;
        m_size   = UniIf_LS.size;
        m_wdata  = UniIf_LS.wdata;
        ls_rdy   = UniIf_M.ready;
      end
      default: ;
    endcase
  end

  assign UniIf_M.valid  = m_valid;
  assign UniIf_M.reqtyp = m_reqtyp;
  assign UniIf_M.addr   = m_addr;
  assign UniIf_M.size   = m_size;
  assign UniIf_M.wdata  = m_wdata;

  assign UniIf_IF.ready = if_rdy;
  assign UniIf_LS.ready = ls_rdy;
  assign UniIf_IF.rdata = UniIf_M.rdata;
  assign UniIf_LS.rdata = UniIf_M.rdata;
  assign UniIf_IF.resp  = UniIf_M.resp;
  assign UniIf_LS.resp  = UniIf_M.resp;

endmodule

// File: tb/tb_uni_arbiter.sv
// tb_uni_arbiter: scoreboard bench for uni_arbiter with a simple bridge model.
// Expected order follows UNI_ARB_RR_EN when defined.
module tb_uni_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] wait_cnt;

  uni_if #(.ADDR_W(32), .DATA_W(64)) ifb ();
  uni_if #(.ADDR_W(32), .DATA_W(64)) lsb ();
  uni_if #(.ADDR_W(32), .DATA_W(64)) mb ();

  uni_arbiter #(
    .UNI_ADDR_WIDTH (32),
    .UNI_DATA_WIDTH (64)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .UniIf_IF (ifb),
    .UniIf_LS (lsb),
    .UniIf_M  (mb),
    .wait_cnt (wait_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rt;
    logic [31:0] a;
    logic [1:0]  sz;
    logic [63:0] wd;
  } req_t;

  typedef struct {
    logic        ls;
    logic [63:0] rd;
    logic [1:0]  rs;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  req_t er;
  rsp_t es;
  int   total = 0;
  int   bad = 0;
  int   lat = 1;
  int   br_cnt = 0;
  bit   in_txn = 0;

  function automatic logic [63:0] mk_rdata(input logic [31:0] a);
    if (a == 32'h8000_0000) return 64'h1122_3344_5566_7788;
    return {a, ~a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic expect_txn(input bit ls, input logic rt,
                            input logic [31:0] a, input logic [1:0] sz,
                            input logic [63:0] wd);
    exp_req.push_back('{rt, a, sz, wd});
    exp_rsp.push_back('{ls, mk_rdata(a), rt ? 2'b01 : 2'b00});
  endtask

  task automatic drive(input bit ls, input logic rt, input logic [31:0] a,
                       input logic [1:0] sz, input logic [63:0] wd);
    if (ls) begin
      lsb.valid = 1'b1; lsb.reqtyp = rt; lsb.addr = a;
      lsb.size = sz; lsb.wdata = wd;
    end else begin
      ifb.valid = 1'b1; ifb.reqtyp = rt; ifb.addr = a;
      ifb.size = sz; ifb.wdata = wd;
    end
  endtask

  task automatic wait_rdy(input bit ls);
    bit got = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = ls ? lsb.ready : ifb.ready;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL timeout_ready side=%0d: got no ready want ready", ls);
    end
  endtask

  task automatic xfer(input bit ls, input logic rt, input logic [31:0] a,
                      input logic [1:0] sz, input logic [63:0] wd);
    @(posedge clk); #2;
    drive(ls, rt, a, sz, wd);
    wait_rdy(ls);
  endtask

  task automatic drop(input bit ls);
    @(posedge clk); #2;
    if (ls) lsb.valid = 1'b0;
    else ifb.valid = 1'b0;
  endtask

  // Bridge model: ready after lat+1 grant cycles, data derived from address.
  initial begin
    mb.ready = 1'b0;
    mb.rdata = '0;
    mb.resp  = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        br_cnt = 0;
        mb.ready = 1'b0;
      end else if (mb.ready) begin
        mb.ready = 1'b0;
      end else if (mb.valid) begin
        if (br_cnt >= lat) begin
          mb.ready = 1'b1;
          mb.rdata = mk_rdata(mb.addr);
          mb.resp  = mb.reqtyp ? 2'b01 : 2'b00;
          br_cnt = 0;
        end else begin
          br_cnt++;
        end
      end
    end
  end

  // Monitor: checks each new downstream request and each upstream return.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_txn = 0;
      end else begin
        if (mb.valid && !in_txn) begin
          in_txn = 1;
          if (exp_req.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_req: got addr %0h want none", mb.addr);
          end else begin
            er = exp_req.pop_front();
            chk("req_reqtyp", 64'(mb.reqtyp), 64'(er.rt));
            chk("req_addr", 64'(mb.addr), 64'(er.a));
            chk("req_size", 64'(mb.size), 64'(er.sz));
            chk("req_wdata", mb.wdata, er.wd);
          end
        end
        if (ifb.ready || lsb.ready) begin
          in_txn = 0;
          if (exp_rsp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got ready want none");
          end else begin
            es = exp_rsp.pop_front();
            chk("rsp_ls_ready", 64'(lsb.ready), 64'(es.ls));
            chk("rsp_if_ready", 64'(ifb.ready), 64'(!es.ls));
            chk("rsp_rdata", es.ls ? lsb.rdata : ifb.rdata, es.rd);
            chk("rsp_resp", 64'(es.ls ? lsb.resp : ifb.resp), 64'(es.rs));
            chk("m_valid_gated", 64'(mb.valid), 64'd0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    ifb.valid = 0; ifb.reqtyp = 0; ifb.addr = 0; ifb.size = 0; ifb.wdata = 0;
    lsb.valid = 0; lsb.reqtyp = 0; lsb.addr = 0; lsb.size = 0; lsb.wdata = 0;

    // reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 64'(mb.valid), 64'd0);
    chk("rst_if_ready", 64'(ifb.ready), 64'd0);
    chk("rst_ls_ready", 64'(lsb.ready), 64'd0);
    chk("rst_wait_cnt", 64'(wait_cnt), 64'd0);
    chk("rst_m_addr", 64'(mb.addr), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // IFU-only read, grant latency
    lat = 2;
    expect_txn(0, 1'b0, 32'h8000_0000, 2'b11, 64'd0);
    @(posedge clk); #2;
    drive(0, 1'b0, 32'h8000_0000, 2'b11, 64'd0);
    @(negedge clk);
    chk("lat_idle_cycle", 64'(mb.valid), 64'd0);
    @(negedge clk);
    chk("lat_grant_cycle", 64'(mb.valid), 64'd1);
    wait_rdy(0);
    drop(0);
    @(negedge clk);
    chk("if_ready_pulse", 64'(ifb.ready), 64'd0);

    // simultaneous requests from reset
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    lat = 1;
    expect_txn(1, 1'b0, 32'h0000_1000, 2'b11, 64'd0);
    expect_txn(0, 1'b0, 32'h8000_0040, 2'b11, 64'd0);
    fork
      begin
        xfer(1, 1'b0, 32'h0000_1000, 2'b11, 64'd0);
        drop(1);
      end
      begin
        xfer(0, 1'b0, 32'h8000_0040, 2'b11, 64'd0);
        drop(0);
      end
    join

    // continuous contention
`ifdef UNI_ARB_RR_EN
    for (int i = 0; i < 3; i++) begin
      expect_txn(1, 1'b0, 32'h0000_2000 + 32'(i * 8), 2'b11, 64'd0);
      expect_txn(0, 1'b0, 32'h8000_0100 + 32'(i * 4), 2'b11, 64'd0);
    end
`else
    for (int i = 0; i < 3; i++)
      expect_txn(1, 1'b0, 32'h0000_2000 + 32'(i * 8), 2'b11, 64'd0);
    for (int i = 0; i < 3; i++)
      expect_txn(0, 1'b0, 32'h8000_0100 + 32'(i * 4), 2'b11, 64'd0);
`endif
    fork
      begin
        for (int i = 0; i < 3; i++)
          xfer(1, 1'b0, 32'h0000_2000 + 32'(i * 8), 2'b11, 64'd0);
        drop(1);
      end
      begin
        for (int j = 0; j < 3; j++)
          xfer(0, 1'b0, 32'h8000_0100 + 32'(j * 4), 2'b11, 64'd0);
        drop(0);
      end
    join

    // LSU write
    expect_txn(1, 1'b1, 32'h0000_3004, 2'b10, 64'hDEAD_BEEF);
    xfer(1, 1'b1, 32'h0000_3004, 2'b10, 64'hDEAD_BEEF);
    chk("wr_ls_valid_held", 64'(lsb.valid), 64'd1);
    chk("wr_m_valid_low", 64'(mb.valid), 64'd0);
    drop(1);

    // reset while LSU is granted
    lat = 30;
    exp_req.push_back('{1'b0, 32'h0000_4000, 2'b11, 64'd0});
    @(posedge clk); #2;
    drive(1, 1'b0, 32'h0000_4000, 2'b11, 64'd0);
    @(posedge clk); #2;
    drive(0, 1'b0, 32'h8000_0300, 2'b11, 64'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_wait_cnt", 64'(wait_cnt), 64'd2);
    chk("mid_m_valid", 64'(mb.valid), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    ifb.valid = 1'b0;
    lsb.valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_m_valid", 64'(mb.valid), 64'd0);
    chk("mrst_if_ready", 64'(ifb.ready), 64'd0);
    chk("mrst_ls_ready", 64'(lsb.ready), 64'd0);
    chk("mrst_wait_cnt", 64'(wait_cnt), 64'd0);
    chk("mrst_m_addr", 64'(mb.addr), 64'd0);

    // wait counter saturation during a long LSU transaction
    lat = 19;
    expect_txn(1, 1'b0, 32'h0000_5000, 2'b11, 64'd0);
    expect_txn(0, 1'b0, 32'h8000_0200, 2'b11, 64'd0);
    fork
      begin
        xfer(1, 1'b0, 32'h0000_5000, 2'b11, 64'd0);
        chk("wait_sat", 64'(wait_cnt), 64'd15);
        drop(1);
        @(negedge clk);
        chk("wait_hold_idle", 64'(wait_cnt), 64'd15);
        @(negedge clk);
        chk("wait_clear_grant", 64'(wait_cnt), 64'd0);
        chk("if_grant_valid", 64'(mb.valid), 64'd1);
      end
      begin
        @(posedge clk);
        xfer(0, 1'b0, 32'h8000_0200, 2'b11, 64'd0);
        drop(0);
      end
    join

    repeat (3) @(negedge clk);
    chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
    chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
